// File: rtl/key8_pkg.sv
// Shared constants and types for the eight-key debouncer.
// Optional synchroniser macro used by the design files: KEY8_SYNC_EN.
package key8_pkg;
    localparam int N_KEYS = 8;
    localparam logic [N_KEYS-1:0] KEY_IDLE = 8'hFF;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } ctrlState_t;
endpackage

// File: rtl/key_debounce_bit.sv
// Single-key conditioner: optional 2-flop synchroniser, stability counter and edge strobes.
// Define KEY8_SYNC_EN to place the synchroniser in front of the counter.
module key_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iKey,
    output logic oStable,
    output logic oPress,
    output logic oChg
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic sample;

`ifdef KEY8_SYNC_EN
    logic [1:0] syncReg;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncReg <= 2'b11;
        end else begin
            syncReg <= {syncReg[0], iKey};
        end
    end

    assign sample = syncReg[1];
`else
    assign sample = iKey;
`endif

    logic [CNT_W-1:0] cntReg;
    logic             stableReg;
    logic             pressReg;
    logic             chgReg;
    logic             accept;

    assign accept = (sample != stableReg) && (cntReg == CNT_LAST);

    // Any cycle where the sample agrees with the stable bit restarts the count.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cntReg    <= '0;
            stableReg <= 1'b1;
            pressReg  <= 1'b0;
            chgReg    <= 1'b0;
        end else begin
            pressReg <= accept & stableReg;
            chgReg   <= accept;
            if (sample == stableReg) begin
                cntReg <= '0;
            end else if (accept) begin
                cntReg    <= '0;
                stableReg <= sample;
            end else begin
                cntReg <= cntReg + 1'b1;
            end
        end
    end

    assign oStable = stableReg;
    assign oPress  = pressReg;
    assign oChg    = chgReg;
endmodule

// File: rtl/key8_debounce.sv
// Eight-key debouncer feeding an 8-to-3 priority encoder, with warm-up gated enable and strobes.
// Define KEY8_SYNC_EN to add a 2-flop synchroniser on every key input.
module key8_debounce
    import key8_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [N_KEYS-1:0] iKey,
    output logic [N_KEYS-1:0] oData,
    output logic              oEI,
    output logic [N_KEYS-1:0] oPress,
    output logic              oChg
);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] stableBits;
    logic [N_KEYS-1:0] pressBits;
    logic [N_KEYS-1:0] chgBits;

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_bit (
                .iClk   (iClk),
                .iRst   (iRst),
                .iKey   (iKey[gi]),
                .oStable(stableBits[gi]),
                .oPress (pressBits[gi]),
                .oChg   (chgBits[gi])
            );
        end
    endgenerate

    ctrlState_t       stateReg;
    logic [CNT_W-1:0] warmCntReg;
    logic             eiReg;

    // Debouncing runs during warm-up; only the encoder enable and strobes wait for it.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg   <= WARMUP;
            warmCntReg <= '0;
            eiReg      <= 1'b1;
        end else begin
            case (stateReg)
                WARMUP: begin
                    if (warmCntReg == WARM_LAST) begin
                        stateReg   <= RUN;
                        warmCntReg <= '0;
                        eiReg      <= 1'b0;
                    end else begin
                        warmCntReg <= warmCntReg + 1'b1;
                    end
                end
                RUN: begin
                    eiReg <= 1'b0;
                end
                default: begin
                    stateReg <= WARMUP;
                end
            endcase
        end
    end

    logic runEn;
    assign runEn = (stateReg == RUN);

    assign oData  = stableBits;
    assign oEI    = eiReg;
    assign oPress = pressBits & {N_KEYS{runEn}};
    assign oChg   = runEn & (|chgBits);
endmodule

// File: tb/tb_key8_debounce.sv
// Self-checking bench for key8_debounce with a sample-history reference model.
// Latency expectations follow KEY8_SYNC_EN as seen by this file.
module tb_key8_debounce;
    localparam int DEB = 4;
`ifdef KEY8_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       iClk = 1'b0;
    logic       iRst;
    logic [7:0] iKey;
    logic [7:0] oData;
    logic       oEI;
    logic [7:0] oPress;
    logic       oChg;

    int passCnt  = 0;
    int checkCnt = 0;

    key8_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iKey  (iKey),
        .oData (oData),
        .oEI   (oEI),
        .oPress(oPress),
        .oChg  (oChg)
    );

    always #5 iClk = ~iClk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key flips once its last DEB samples all disagree with it.
    logic [7:0] sPipe[$];
    logic [7:0] hist[$];
    logic [7:0] mOut, mPress, newOut, s;
    logic       mEI, mChg, allDiff;
    int         since;
    bit         modelValid = 0;

    always @(posedge iClk) begin
        if (iRst) begin
            sPipe.delete();
            hist.delete();
            for (int i = 0; i < LAT; i++) sPipe.push_back(8'hFF);
            for (int i = 0; i < DEB; i++) hist.push_back(8'hFF);
            mOut = 8'hFF; mPress = 8'h00; mChg = 1'b0; mEI = 1'b1;
            since = 0;
            modelValid = 1;
        end else if (modelValid) begin
            sPipe.push_back(iKey);
            s = sPipe.pop_front();
            hist.push_back(s);
            void'(hist.pop_front());
            newOut = mOut;
            for (int k = 0; k < 8; k++) begin
                allDiff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (hist[j][k] == mOut[k]) allDiff = 1'b0;
                if (allDiff) newOut[k] = ~mOut[k];
            end
            if (since < DEB) since++;
            mEI    = (since < DEB);
            mPress = mEI ? 8'h00 : (mOut & ~newOut);
            mChg   = !mEI && (newOut != mOut);
            mOut   = newOut;
        end
    end

    always @(negedge iClk) begin
        if (modelValid) begin
            check8("cyc_oData", oData, mOut);
            check8("cyc_oEI", {7'd0, oEI}, {7'd0, mEI});
            check8("cyc_oPress", oPress, mPress);
            check8("cyc_oChg", {7'd0, oChg}, {7'd0, mChg});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    initial begin
        iRst = 1'b1;
        iKey = 8'hFF;
        step(2);
        check8("rst_oData", oData, 8'hFF);
        check8("rst_oEI", {7'd0, oEI}, 8'd1);
        check8("rst_oPress", oPress, 8'h00);
        check8("rst_oChg", {7'd0, oChg}, 8'd0);
        iRst = 1'b0;
        step(3);
        check8("warm_oEI_hi", {7'd0, oEI}, 8'd1);
        step(1);
        check8("warm_oEI_lo", {7'd0, oEI}, 8'd0);
        step(2);

        // Single press on key 7.
        iKey = 8'b0111_1111;
        step(DEB + LAT - 1);
        check8("press_early", oData, 8'hFF);
        step(1);
        check8("press_oData", oData, 8'h7F);
        check8("press_oPress", oPress, 8'h80);
        check8("press_oChg", {7'd0, oChg}, 8'd1);
        step(1);
        check8("press_pulse_end", oPress, 8'h00);
        check8("press_chg_end", {7'd0, oChg}, 8'd0);
        iKey = 8'hFF;
        step(DEB + LAT + 3);

        // Bounce shorter than the debounce window.
        iKey = 8'b1111_1101;
        step(3);
        iKey = 8'hFF;
        step(DEB + LAT + 4);
        check8("bounce_oData", oData, 8'hFF);

        // Two keys falling together.
        iKey = 8'b1111_1001;
        step(DEB + LAT);
        check8("simul_oData", oData, 8'hF9);
        check8("simul_oPress", oPress, 8'h06);
        check8("simul_oChg", {7'd0, oChg}, 8'd1);
        step(2);

        // Release of both keys.
        iKey = 8'hFF;
        step(DEB + LAT);
        check8("rel_oData", oData, 8'hFF);
        check8("rel_oChg", {7'd0, oChg}, 8'd1);
        check8("rel_oPress", oPress, 8'h00);
        step(2);

        // Reset while key 0 is partway through its count.
        iKey = 8'b1111_1110;
        step(3);
        iRst = 1'b1;
        step(1);
        check8("mid_oData", oData, 8'hFF);
        check8("mid_oEI", {7'd0, oEI}, 8'd1);
        check8("mid_oPress", oPress, 8'h00);
        iRst = 1'b0;
        step(3);
        check8("rewarm_oEI_hi", {7'd0, oEI}, 8'd1);
        step(1);
        check8("rewarm_oEI_lo", {7'd0, oEI}, 8'd0);
        step(10);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
